// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/response encodings and the data-phase enums.
// Supplies default widths for `AHB_DATA_BITS and `AHB_ADDR_BITS when not set by the build.
`ifndef AHB_DATA_BITS
`define AHB_DATA_BITS 32
`endif
`ifndef AHB_ADDR_BITS
`define AHB_ADDR_BITS 32
`endif

package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {SEL_NONE, SEL_S1, SEL_S2, SEL_DEF} sel_e;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

  // Fixed priority S1 > S2 > default, so overlapping selects still resolve.
  function automatic sel_e decode_sel(input logic s1, input logic s2, input logic sdef);
    if (s1)        return SEL_S1;
    else if (s2)   return SEL_S2;
    else if (sdef) return SEL_DEF;
    else           return SEL_NONE;
  endfunction
endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response to active transfers into unmapped space.
// With AHB_MUX_ERR_LOG_EN defined, also latches the address of the first error.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int RESP_W = 2,
  parameter int ADDR_W = `AHB_ADDR_BITS
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              hready,
  input  logic              sel_def,
  input  logic              trans_active,
`ifdef AHB_MUX_ERR_LOG_EN
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              ERR_CLR,
  output logic              ERR_VALID,
  output logic [ADDR_W-1:0] ERR_ADDR,
`endif
  output logic              ds_hready,
  output logic [RESP_W-1:0] ds_hresp
);
  ds_state_e state_q, state_d;
  logic      access;

  assign access = hready & sel_def & trans_active;

  always_comb begin
    state_d   = state_q;
    ds_hready = 1'b1;
    ds_hresp  = RESP_W'(RESP_OKAY);
    case (state_q)
      DS_IDLE: if (access) state_d = DS_ERR1;
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = RESP_W'(RESP_ERROR);
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        ds_hresp = RESP_W'(RESP_ERROR);
        state_d  = access ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= DS_IDLE;
    else        state_q <= state_d;
  end

`ifdef AHB_MUX_ERR_LOG_EN
  logic err_start;
  assign err_start = (state_d == DS_ERR1) && (state_q != DS_ERR1);

  // Sticky log: first error wins, clear has priority over a new capture.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= '0;
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
    end else if (err_start && !ERR_VALID) begin
      ERR_VALID <= 1'b1;
      ERR_ADDR  <= HADDR;
    end
  end
`endif
endmodule

// File: rtl/ahb_slave_mux.sv
// AHB data-phase response mux: registers the decoder select and steers HRDATA/HREADY/HRESP.
// Optional error address log enabled by defining AHB_MUX_ERR_LOG_EN.
module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int DATA_W = `AHB_DATA_BITS,
  parameter int RESP_W = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSEL_S1,
  input  logic                      HSEL_S2,
  input  logic                      HSELDefault,
  input  logic [1:0]                HTRANS,
  input  logic [DATA_W-1:0]         HRDATA_S1,
  input  logic                      HREADY_S1,
  input  logic [RESP_W-1:0]         HRESP_S1,
  input  logic [DATA_W-1:0]         HRDATA_S2,
  input  logic                      HREADY_S2,
  input  logic [RESP_W-1:0]         HRESP_S2,
`ifdef AHB_MUX_ERR_LOG_EN
  input  logic [`AHB_ADDR_BITS-1:0] HADDR,
  input  logic                      ERR_CLR,
  output logic                      ERR_VALID,
  output logic [`AHB_ADDR_BITS-1:0] ERR_ADDR,
`endif
  output logic [DATA_W-1:0]         HRDATA,
  output logic                      HREADY,
  output logic [RESP_W-1:0]         HRESP
);
  sel_e              sel_q, sel_d;
  logic              ds_hready;
  logic [RESP_W-1:0] ds_hresp;
  logic              unused_htrans_lsb;

  assign unused_htrans_lsb = HTRANS[0];
  assign sel_d = decode_sel(HSEL_S1, HSEL_S2, HSELDefault);

  // Address phase is accepted only when the current data phase completes.
  always_ff @(posedge HCLK) begin
    if (HRESET)      sel_q <= SEL_NONE;
    else if (HREADY) sel_q <= sel_d;
  end

  ahb_default_slave #(
    .RESP_W (RESP_W)
  ) u_default_slave (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .hready       (HREADY),
    .sel_def      (sel_d == SEL_DEF),
    .trans_active (HTRANS[1]),
`ifdef AHB_MUX_ERR_LOG_EN
    .HADDR        (HADDR),
    .ERR_CLR      (ERR_CLR),
    .ERR_VALID    (ERR_VALID),
    .ERR_ADDR     (ERR_ADDR),
`endif
    .ds_hready    (ds_hready),
    .ds_hresp     (ds_hresp)
  );

  always_comb begin
    HRDATA = '0;
    HREADY = ds_hready;
    HRESP  = ds_hresp;
    case (sel_q)
      SEL_S1: begin
        HRDATA = HRDATA_S1;
        HREADY = HREADY_S1;
        HRESP  = HRESP_S1;
      end
      SEL_S2: begin
        HRDATA = HRDATA_S2;
        HREADY = HREADY_S2;
        HRESP  = HRESP_S2;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/ahb_slave_mux.md
Name: ahb_slave_mux

Overview:
- Data-phase response multiplexer, directly downstream of the AHB address decoder.
- Registers the decoder's HSEL_S1 / HSEL_S2 / HSELDefault at each address-phase acceptance.
- During the following data phase, steers the selected slave's HRDATA/HREADY/HRESP back to the master.
- Embeds the default slave, which returns a two-cycle ERROR response to any active transfer to unmapped space.

Parameters:
- DATA_W, `AHB_DATA_BITS (32): width of HRDATA buses.
- RESP_W, 2: HRESP width. Encoding: OKAY=00, ERROR=01, RETRY=10, SPLIT=11.

Ports:
- HCLK  in  1  system clock; all state on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL_S1  in  1  decoder select, slave 1 (address phase).
- HSEL_S2  in  1  decoder select, slave 2 (address phase).
- HSELDefault  in  1  decoder select, unmapped space (address phase).
- HTRANS  in  2  master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HRDATA_S1  in  DATA_W  slave 1 read data.
- HREADY_S1  in  1  slave 1 ready.
- HRESP_S1  in  RESP_W  slave 1 response.
- HRDATA_S2  in  DATA_W  slave 2 read data.
- HREADY_S2  in  1  slave 2 ready.
- HRESP_S2  in  RESP_W  slave 2 response.
- HRDATA  out  DATA_W  muxed read data to master.
- HREADY  out  1  muxed ready; also fed back to all slaves as HREADY input.
- HRESP  out  RESP_W  muxed response to master.

Behaviour:
- Data-phase select register sel_q, enum {SEL_NONE, SEL_S1, SEL_S2, SEL_DEF}.
  - Reset value: SEL_NONE.
  - Loads only on cycles where output HREADY=1; holds otherwise.
  - Load value: HSEL_S1 -> SEL_S1; else HSEL_S2 -> SEL_S2; else HSELDefault -> SEL_DEF; else SEL_NONE.
  - Priority S1 > S2 > Default applies when multiple selects are high (illegal, but defined).
  - Loads regardless of HTRANS; selected slaves answer IDLE/BUSY with zero-wait OKAY themselves.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2; reset state DS_IDLE.
  - DS_IDLE: if HREADY=1, HSELDefault=1 (winning priority) and HTRANS[1]=1 -> DS_ERR1; else stay.
  - DS_ERR1: drives HREADY=0, HRESP=ERROR. Always -> DS_ERR2.
  - DS_ERR2: drives HREADY=1, HRESP=ERROR. If a new qualifying default access is sampled this cycle -> DS_ERR1; else -> DS_IDLE.
  - DS_IDLE contribution: HREADY=1, HRESP=OKAY.
- Output mux, purely combinational from sel_q and the FSM (no added latency):
  - SEL_S1: slave 1 signals passed through.
  - SEL_S2: slave 2 signals passed through.
  - SEL_DEF / SEL_NONE: HRDATA=0; HREADY and HRESP from the FSM.
- Idle/busy transfer to default space: sel_q=SEL_DEF, FSM stays DS_IDLE, zero-wait OKAY.
- Slave wait states: sel_q held while HREADY_Sx=0; decoder inputs ignored until HREADY returns to 1.
- Back-to-back S1 then S2 with S1 inserting a wait: sel_q changes only on the cycle S1's HREADY_S1=1.
- Reset mid-operation (e.g. in DS_ERR1 or during a slave wait): next edge gives sel_q=SEL_NONE, FSM=DS_IDLE.
- Outputs after any reset edge: HREADY=1, HRESP=OKAY, HRDATA=0; stable while HRESET held.

Optional Feature:
- Macro: AHB_MUX_ERR_LOG_EN.
- When defined, adds ports:
  - HADDR in `AHB_ADDR_BITS.
  - ERR_CLR in 1.
  - ERR_VALID out 1.
  - ERR_ADDR out `AHB_ADDR_BITS.
- Capture: on the DS_IDLE->DS_ERR1 or DS_ERR2->DS_ERR1 transition with ERR_VALID=0, HADDR is captured to ERR_ADDR and ERR_VALID is set.
- Sticky: ERR_VALID=1 holds until ERR_CLR=1 (clear wins over a simultaneous capture). Later errors do not overwrite.
- Reset value of both outputs: 0.
- When undefined, these ports and registers do not exist.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_* constants.
  - RESP_OKAY / RESP_ERROR / RESP_RETRY / RESP_SPLIT.
  - sel_e enum.
  - ds_state_e enum.
- One sub-module: ahb_default_slave (FSM plus HREADY/HRESP generation, and the error log when enabled).
- The mux and sel_q stay in ahb_slave_mux.

Test Plan:
- Reset held 3 cycles, then released with all HSEL=0 -> HREADY=1, HRESP=00, HRDATA=0.
- NONSEQ to S1, HREADY_S1=1, HRDATA_S1=32'hCAFE_0001 -> HRDATA=32'hCAFE_0001 one cycle after the address phase.
- NONSEQ to S1 with HREADY_S1 low for 2 cycles, then pipelined NONSEQ to S2 -> S2 data appears only after S1 completes; sel_q steady during the waits.
- NONSEQ to default space -> HREADY=0, HRESP=01, then HREADY=1, HRESP=01, then OKAY. Back-to-back default NONSEQs -> ERR1/ERR2 pairs with no idle gap.
- IDLE transfer with HSELDefault=1 -> zero-wait OKAY, FSM never leaves DS_IDLE.
- HRESET asserted during DS_ERR1 -> next cycle HREADY=1, HRESP=00. With AHB_MUX_ERR_LOG_EN: error at HADDR=32'h7000_0010 -> ERR_VALID=1, ERR_ADDR=32'h7000_0010; second error doesn't overwrite; ERR_CLR clears.
